// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register with writeback mux and WB->EX forwarding flags.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module mem_wb_writeback #(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  mem_valid,
   input  logic                  mem_RegWrite,
   input  logic                  mem_MemtoReg,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic [XLEN-1:0]       mem_alu_result,
   input  logic [XLEN-1:0]       mem_read_data,
   input  logic [REG_ADDR_W-1:0] ex_rs1,
   input  logic [REG_ADDR_W-1:0] ex_rs2,
   output logic                  wb_valid,
   output logic                  RegWrite,
   output logic [REG_ADDR_W-1:0] addr,
   output logic [XLEN-1:0]       write_data,
   output logic                  fwd_a,
   output logic                  fwd_b,
   output logic [63:0]           retire_count
);

   logic                  r_valid;
   logic                  r_regwrite;
   logic                  r_memtoreg;
   logic [REG_ADDR_W-1:0] r_rd;
   logic [XLEN-1:0]       r_alu;
   logic [XLEN-1:0]       r_rdata;

   logic                  w_load_rw;
   logic                  w_regwrite;

   // Gating with mem_valid/mem_RegWrite keeps an undefined MemtoReg (stores, branches) out of the pipe.
   assign w_load_rw = mem_valid & mem_RegWrite;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid    <= 1'b0;
         r_regwrite <= 1'b0;
         r_memtoreg <= 1'b0;
         r_rd       <= '0;
         r_alu      <= '0;
         r_rdata    <= '0;
      end else if (flush) begin
         r_valid    <= 1'b0;
         r_regwrite <= 1'b0;
         r_memtoreg <= 1'b0;
         r_rd       <= '0;
         r_alu      <= '0;
         r_rdata    <= '0;
      end else if (!stall) begin
         r_valid    <= mem_valid;
         r_regwrite <= w_load_rw;
         r_memtoreg <= w_load_rw & mem_MemtoReg;
         r_rd       <= mem_rd;
         r_alu      <= mem_alu_result;
         r_rdata    <= mem_read_data;
      end
   end

   assign w_regwrite = r_valid & r_regwrite & (|r_rd);

   assign wb_valid   = r_valid;
   assign RegWrite   = w_regwrite;
   assign addr       = r_rd;
   assign write_data = r_memtoreg ? r_rdata : r_alu;
   assign fwd_a      = w_regwrite & (r_rd == ex_rs1);
   assign fwd_b      = w_regwrite & (r_rd == ex_rs2);

`ifdef WB_RETIRE_CNT_EN
   logic [63:0] r_retire_cnt;

   // An instruction leaves WB when the stage advances; a flush evicts it even under stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_retire_cnt <= '0;
      end else if (r_valid & (flush | ~stall)) begin
         r_retire_cnt <= r_retire_cnt + 64'd1;
      end
   end

   assign retire_count = r_retire_cnt;
`else
   assign retire_count = '0;
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback: expected WB state is queued when stimulus is
// driven and popped one edge later; define WB_RETIRE_CNT_EN to also check the counter.
module tb_mem_wb_writeback;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic        mem_valid;
   logic        mem_RegWrite;
   logic        mem_MemtoReg;
   logic [4:0]  mem_rd;
   logic [63:0] mem_alu_result;
   logic [63:0] mem_read_data;
   logic [4:0]  ex_rs1;
   logic [4:0]  ex_rs2;
   logic        wb_valid;
   logic        RegWrite;
   logic [4:0]  addr;
   logic [63:0] write_data;
   logic        fwd_a;
   logic        fwd_b;
   logic [63:0] retire_count;

   mem_wb_writeback #(.XLEN(64), .REG_ADDR_W(5)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .flush          (flush),
      .mem_valid      (mem_valid),
      .mem_RegWrite   (mem_RegWrite),
      .mem_MemtoReg   (mem_MemtoReg),
      .mem_rd         (mem_rd),
      .mem_alu_result (mem_alu_result),
      .mem_read_data  (mem_read_data),
      .ex_rs1         (ex_rs1),
      .ex_rs2         (ex_rs2),
      .wb_valid       (wb_valid),
      .RegWrite       (RegWrite),
      .addr           (addr),
      .write_data     (write_data),
      .fwd_a          (fwd_a),
      .fwd_b          (fwd_b),
      .retire_count   (retire_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // register file consumer, committing on the falling edge
   logic [63:0] rf [32];
   always @(negedge clk) if (RegWrite === 1'b1) rf[addr] <= write_data;

   typedef struct {
      logic        v;
      logic        rw;
      logic [4:0]  a;
      logic [63:0] d;
      logic [63:0] cnt;
   } exp_t;
   exp_t q[$];

   int unsigned n_checks;
   int unsigned n_fail;

   // reference model of the WB stage
   logic        m_v, m_rw, m_m2r;
   logic [4:0]  m_rd;
   logic [63:0] m_alu, m_rdata, m_cnt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_v = 1'b0; m_rw = 1'b0; m_m2r = 1'b0; m_rd = '0;
      m_alu = '0; m_rdata = '0; m_cnt = '0;
   endtask

   task automatic step(input logic st, input logic fl, input logic v, input logic rw,
                       input logic m2r, input logic [4:0] rd,
                       input logic [63:0] alu, input logic [63:0] rdata);
      exp_t e;
      stall = st; flush = fl;
      mem_valid = v; mem_RegWrite = rw; mem_MemtoReg = m2r; mem_rd = rd;
      mem_alu_result = alu; mem_read_data = rdata;
      if (m_v && (fl || !st)) m_cnt = m_cnt + 64'd1;
      if (fl) begin
         m_v = 1'b0; m_rw = 1'b0; m_m2r = 1'b0; m_rd = '0; m_alu = '0; m_rdata = '0;
      end else if (!st) begin
         m_v = v; m_rw = v & rw; m_m2r = v & rw & (m2r === 1'b1);
         m_rd = rd; m_alu = alu; m_rdata = rdata;
      end
      e.v   = m_v;
      e.rw  = m_v & m_rw & (m_rd != 5'd0);
      e.a   = m_rd;
      e.d   = m_m2r ? m_rdata : m_alu;
      e.cnt = m_cnt;
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      check("wb_valid", {63'd0, wb_valid}, {63'd0, e.v});
      check("RegWrite", {63'd0, RegWrite}, {63'd0, e.rw});
      check("addr", {59'd0, addr}, {59'd0, e.a});
      check("write_data", write_data, e.d);
`ifdef WB_RETIRE_CNT_EN
      check("retire_count", retire_count, e.cnt);
`else
      check("retire_count_tied", retire_count, 64'd0);
`endif
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      foreach (rf[i]) rf[i] = '0;
      model_reset();
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      mem_valid = 1'b0; mem_RegWrite = 1'b0; mem_MemtoReg = 1'b0; mem_rd = '0;
      mem_alu_result = '0; mem_read_data = '0; ex_rs1 = '0; ex_rs2 = '0;
      #3;
      check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
      check("rst_RegWrite", {63'd0, RegWrite}, 64'd0);
      check("rst_write_data", write_data, 64'd0);
      check("rst_retire_count", retire_count, 64'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // ALU writeback
      step(0, 0, 1, 1, 0, 5'd5, 64'h1234, 64'h9999);
      check("alu_RegWrite", {63'd0, RegWrite}, 64'd1);
      check("alu_data", write_data, 64'h1234);

      // load writeback and regfile commit on the following negedge
      step(0, 0, 1, 1, 1, 5'd7, 64'h40, 64'hDEADBEEF);
      check("load_data", write_data, 64'hDEADBEEF);
      @(negedge clk); #1;
      check("rf_x7", rf[7], 64'hDEADBEEF);

      // full-width data, no truncation
      step(0, 0, 1, 1, 0, 5'd31, 64'hFEDC_BA98_7654_3210, 64'h0);

      // x0 destination never writes or forwards
      step(0, 0, 1, 1, 0, 5'd0, 64'h55, 64'h66);
      ex_rs1 = 5'd0; ex_rs2 = 5'd0; #1;
      check("x0_fwd_a", {63'd0, fwd_a}, 64'd0);
      check("x0_fwd_b", {63'd0, fwd_b}, 64'd0);

      // store with undefined MemtoReg: no write, ALU result selected
      step(0, 0, 1, 0, 1'bx, 5'd2, 64'hABCD, 64'h7777);
      check("sd_no_x", {63'd0, ^write_data === 1'bx}, 64'd0);

      // forwarding
      step(0, 0, 1, 1, 0, 5'd3, 64'h33, 64'h0);
      ex_rs1 = 5'd3; ex_rs2 = 5'd3; #1;
      check("fwd_a_hit", {63'd0, fwd_a}, 64'd1);
      check("fwd_b_hit", {63'd0, fwd_b}, 64'd1);
      ex_rs2 = 5'd4; #1;
      check("fwd_b_miss", {63'd0, fwd_b}, 64'd0);
      check("fwd_a_still", {63'd0, fwd_a}, 64'd1);

      // stall holds rd=9 for three cycles, then flush wins over stall
      step(0, 0, 1, 1, 0, 5'd9, 64'h9090, 64'h0);
      for (int k = 0; k < 3; k++) begin
         step(1, 0, 1, 1, 1, 5'd12, 64'hBAD, 64'hBAD);
         check("stall_addr", {59'd0, addr}, 64'd9);
         check("stall_data", write_data, 64'h9090);
      end
      step(1, 1, 1, 1, 0, 5'd13, 64'h1, 64'h2);
      check("flush_valid", {63'd0, wb_valid}, 64'd0);
      check("flush_RegWrite", {63'd0, RegWrite}, 64'd0);
      step(0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0);

      // asynchronous reset mid-stream while a write is pending
      step(0, 0, 1, 1, 0, 5'd10, 64'hCAFE, 64'h0);
      check("pre_rst_RegWrite", {63'd0, RegWrite}, 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_wb_valid", {63'd0, wb_valid}, 64'd0);
      check("arst_RegWrite", {63'd0, RegWrite}, 64'd0);
      check("arst_addr", {59'd0, addr}, 64'd0);
      check("arst_data", write_data, 64'd0);
      check("arst_count", retire_count, 64'd0);
      model_reset();
      #1 rst_n = 1'b1;

      // ten back-to-back instructions, then a bubble drains the last one
      for (int k = 0; k < 10; k++)
         step(0, 0, 1, 1, k[0], 5'(k + 1), 64'(k * 3), 64'(k * 5 + 1));
      step(0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0);
`ifdef WB_RETIRE_CNT_EN
      check("retire_ten", retire_count, 64'd10);
`endif

      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain observed=%0d expected=0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
